// File: rtl/key_counter_pkg.sv
// Shared types and the BCD increment datapath for the pushbutton event counter.
package key_counter_pkg;

  localparam int NUM_DIGITS = 6;

  typedef logic [3:0] bcd_digit_t;
  typedef bcd_digit_t [NUM_DIGITS-1:0] bcd_count_t;

  typedef enum logic [1:0] {
    IDLE,
    HELD,
    REPEAT
  } cnt_state_t;

  typedef struct packed {
    bcd_count_t value;
    logic       carry;
  } bcd_inc_t;

  // Ripple-carry decimal increment; carry out of the top digit marks the wrap.
  function automatic bcd_inc_t bcd_increment(input bcd_count_t count);
    bcd_inc_t res;
    logic     carry;
    carry = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (carry && (count[i] == 4'd9)) begin
        res.value[i] = 4'd0;
      end else if (carry) begin
        res.value[i] = count[i] + 4'd1;
        carry        = 1'b0;
      end else begin
        res.value[i] = count[i];
      end
    end
    res.carry = carry;
    return res;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One pushbutton: 2-FF synchroniser, stability-count debouncer and press pulse.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_i,
  output logic db_o,
  output logic press_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          meta_q, sync_q;
  logic          db_q, db_d;
  logic          armed_q, armed_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Presses are only honoured once the key has been seen stably released
  // after reset, so a key held through reset must be released first.
  always_comb begin
    db_d    = db_q;
    cnt_d   = '0;
    armed_d = armed_q;
    press_d = 1'b0;
    if (sync_q != db_q) begin
      if (cnt_q == CNT_MAX) begin
        db_d    = sync_q;
        press_d = db_q & armed_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (!armed_q && sync_q) begin
      if (cnt_q == CNT_MAX) begin
        armed_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q  <= 1'b1;
      sync_q  <= 1'b1;
      db_q    <= 1'b1;
      armed_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      meta_q  <= key_i;
      sync_q  <= meta_q;
      db_q    <= db_d;
      armed_q <= armed_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign db_o    = db_q;
  assign press_o = press_q;

endmodule

// File: rtl/key_bcd_counter.sv
// Six-digit BCD press counter: KEY[1] counts with hold-to-repeat, KEY[0] clears.
module key_bcd_counter
  import key_counter_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int HOLD_CYCLES     = 25000000,
  parameter int REPEAT_CYCLES   = 5000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  KEY,
  output logic [23:0] bcd,
  output logic        changed,
  output logic        overflow
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int RW = $clog2(REPEAT_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES - 1);
  localparam logic [RW-1:0] REP_MAX  = RW'(REPEAT_CYCLES - 1);

  logic [1:0]    db;
  logic [1:0]    press;
  logic          unused_db0;
  cnt_state_t    state_q;
  logic [HW-1:0] hold_q;
  logic [RW-1:0] rep_q;
  bcd_count_t    count_q;
  logic          changed_q, overflow_q;
  logic          inc_req;
  bcd_inc_t      inc_res;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_key
      key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_key_debounce (
        .clk    (clk),
        .rst    (rst),
        .key_i  (KEY[gi]),
        .db_o   (db[gi]),
        .press_o(press[gi])
      );
    end
  endgenerate

  // The clear key acts only on its press event; its level is not needed.
  assign unused_db0 = db[0];

  assign inc_res = bcd_increment(count_q);

  always_comb begin
    inc_req = 1'b0;
    case (state_q)
      IDLE:    inc_req = press[1];
      HELD:    inc_req = !db[1] && (hold_q == HOLD_MAX);
      REPEAT:  inc_req = !db[1] && (rep_q == REP_MAX);
      default: inc_req = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      rep_q      <= '0;
      count_q    <= '0;
      changed_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (press[1]) begin
            state_q <= HELD;
            hold_q  <= '0;
          end
        end
        HELD: begin
          if (db[1]) begin
            state_q <= IDLE;
          end else if (hold_q == HOLD_MAX) begin
            state_q <= REPEAT;
            rep_q   <= '0;
          end else begin
            hold_q <= hold_q + 1'b1;
          end
        end
        REPEAT: begin
          if (db[1]) begin
            state_q <= IDLE;
          end else if (rep_q == REP_MAX) begin
            rep_q <= '0;
          end else begin
            rep_q <= rep_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase

      // Clear has priority over a coincident increment.
      changed_q <= 1'b0;
      if (press[0]) begin
        count_q    <= '0;
        overflow_q <= 1'b0;
        changed_q  <= (count_q != '0) || overflow_q;
      end else if (inc_req) begin
        count_q   <= inc_res.value;
        changed_q <= 1'b1;
        if (inc_res.carry) begin
          overflow_q <= 1'b1;
        end
      end
    end
  end

  assign bcd      = count_q;
  assign changed  = changed_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_key_bcd_counter.sv
// Scoreboard bench: each expected changed pulse (value, overflow, edge) is queued at stimulus time.
module tb_key_bcd_counter;

  localparam int DEB  = 4;
  localparam int HOLD = 20;
  localparam int REP  = 5;
  localparam int LAT  = DEB + 3;  // drive at negedge c -> update at edge c+LAT

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  key = 2'b11;
  logic [23:0] bcd;
  logic        changed;
  logic        overflow;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [23:0] bcd;
    logic        ovf;
    int          edge_no;
  } exp_t;

  exp_t exp_q[$];

  key_bcd_counter #(
    .DEBOUNCE_CYCLES(DEB),
    .HOLD_CYCLES    (HOLD),
    .REPEAT_CYCLES  (REP)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .KEY     (key),
    .bcd     (bcd),
    .changed (changed),
    .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Every changed pulse must match the head of the scoreboard, including its edge.
  always @(negedge clk) begin
    if (changed === 1'b1) begin
      exp_t e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_changed cyc=%0d bcd=%h ovf=%b required no pulse", cyc, bcd, overflow);
      end else begin
        e = exp_q.pop_front();
        if (bcd !== e.bcd || overflow !== e.ovf || cyc != e.edge_no) begin
          errors++;
          $display("FAIL changed_pulse got bcd=%h ovf=%b cyc=%0d required bcd=%h ovf=%b cyc=%0d",
                   bcd, overflow, cyc, e.bcd, e.ovf, e.edge_no);
        end else begin
          $display("txn cyc=%0d bcd=%h ovf=%b ok", cyc, bcd, overflow);
        end
      end
    end
  end

  task automatic expect_pulse(input logic [23:0] v, input logic ovf, input int edge_no);
    exp_t e;
    e.bcd     = v;
    e.ovf     = ovf;
    e.edge_no = edge_no;
    exp_q.push_back(e);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    key = 2'b11;
    wait_cycles(3);
    checks++;
    if (bcd !== 24'h0 || changed !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_values got bcd=%h changed=%b ovf=%b required 000000/0/0", bcd, changed, overflow);
    end
    rst = 1'b0;
    wait_cycles(10);
    checks++;
    if (bcd !== 24'h0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset got bcd=%h ovf=%b required 000000/0", bcd, overflow);
    end
  endtask

  task automatic test_single_press();
    int c;
    c = cyc;
    key[1] = 1'b0;
    expect_pulse(24'h000001, 1'b0, c + LAT);
    wait_cycles(LAT - 1);
    checks++;
    if (bcd !== 24'h0) begin
      errors++;
      $display("FAIL latency_early got bcd=%h required 000000 one edge before update", bcd);
    end
    wait_cycles(10 - (LAT - 1));
    key[1] = 1'b1;
    wait_cycles(25);
    checks++;
    if (bcd !== 24'h000001 || overflow !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL single_press got bcd=%h ovf=%b pending=%0d required 000001/0/0", bcd, overflow, exp_q.size());
    end
  endtask

  task automatic test_glitch();
    int c;
    c = cyc;
    key[0] = 1'b0;
    expect_pulse(24'h000000, 1'b0, c + LAT);
    wait_cycles(8);
    key[0] = 1'b1;
    wait_cycles(10);
    for (int i = 0; i < 3; i++) begin
      key[1] = 1'b0;
      wait_cycles(3);
      key[1] = 1'b1;
      wait_cycles(2);
    end
    wait_cycles(20);
    checks++;
    if (bcd !== 24'h0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL glitch_reject got bcd=%h pending=%0d required 000000/0", bcd, exp_q.size());
    end
  endtask

  task automatic test_auto_repeat();
    int c;
    c = cyc;
    key[1] = 1'b0;
    expect_pulse(24'h000001, 1'b0, c + LAT);
    for (int k = 0; k < 7; k++) begin
      expect_pulse(24'(k + 2), 1'b0, c + LAT + HOLD + REP * k);
    end
    wait_cycles(55);
    key[1] = 1'b1;
    wait_cycles(30);
    checks++;
    if (bcd !== 24'h000008 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL auto_repeat got bcd=%h pending=%0d required 000008/0", bcd, exp_q.size());
    end
  endtask

  task automatic test_overflow();
    int c;
    c = cyc;
    key[1] = 1'b0;
    expect_pulse(24'h000009, 1'b0, c + LAT);
    expect_pulse(24'h000010, 1'b0, c + LAT + HOLD);
    expect_pulse(24'h000011, 1'b0, c + LAT + HOLD + REP);
    expect_pulse(24'h000000, 1'b1, c + LAT + HOLD + 2 * REP);
    wait_cycles(LAT + HOLD + REP + 1);
    force dut.count_q = 24'h999999;
    wait_cycles(1);
    release dut.count_q;
    wait_cycles(1);
    key[1] = 1'b1;
    wait_cycles(3);
    checks++;
    if (bcd !== 24'h0 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL wrap got bcd=%h ovf=%b required 000000/1", bcd, overflow);
    end
    wait_cycles(20);
    checks++;
    if (overflow !== 1'b1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL overflow_sticky got ovf=%b pending=%0d required 1/0", overflow, exp_q.size());
    end
    c = cyc;
    key[0] = 1'b0;
    expect_pulse(24'h000000, 1'b0, c + LAT);
    wait_cycles(8);
    key[0] = 1'b1;
    wait_cycles(15);
    checks++;
    if (overflow !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL clear_overflow got ovf=%b pending=%0d required 0/0", overflow, exp_q.size());
    end
    key[0] = 1'b0;
    wait_cycles(8);
    key[0] = 1'b1;
    wait_cycles(15);
    checks++;
    if (bcd !== 24'h0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL clear_at_zero got bcd=%h ovf=%b required 000000/0", bcd, overflow);
    end
  endtask

  task automatic test_clear_and_count();
    int c;
    force dut.count_q = 24'h000123;
    wait_cycles(1);
    release dut.count_q;
    wait_cycles(2);
    checks++;
    if (bcd !== 24'h000123) begin
      errors++;
      $display("FAIL preload_123 got bcd=%h required 000123", bcd);
    end
    c = cyc;
    key = 2'b00;
    expect_pulse(24'h000000, 1'b0, c + LAT);
    expect_pulse(24'h000001, 1'b0, c + LAT + HOLD);
    wait_cycles(22);
    key = 2'b11;
    wait_cycles(25);
    checks++;
    if (bcd !== 24'h000001 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL clear_wins got bcd=%h pending=%0d required 000001/0", bcd, exp_q.size());
    end
  endtask

  task automatic test_reset_mid_repeat();
    int c;
    force dut.count_q = 24'h000040;
    wait_cycles(1);
    release dut.count_q;
    wait_cycles(2);
    c = cyc;
    key[1] = 1'b0;
    expect_pulse(24'h000041, 1'b0, c + LAT);
    expect_pulse(24'h000042, 1'b0, c + LAT + HOLD);
    wait_cycles(LAT + HOLD + 2);
    rst = 1'b1;
    #1;
    checks++;
    if (bcd !== 24'h0 || changed !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got bcd=%h changed=%b ovf=%b required 000000/0/0", bcd, changed, overflow);
    end
    wait_cycles(3);
    rst = 1'b0;
    wait_cycles(40);
    checks++;
    if (bcd !== 24'h0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL held_through_reset got bcd=%h pending=%0d required 000000/0", bcd, exp_q.size());
    end
    key[1] = 1'b1;
    wait_cycles(15);
    c = cyc;
    key[1] = 1'b0;
    expect_pulse(24'h000001, 1'b0, c + LAT);
    wait_cycles(10);
    key[1] = 1'b1;
    wait_cycles(20);
    checks++;
    if (bcd !== 24'h000001 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL repress_after_reset got bcd=%h pending=%0d required 000001/0", bcd, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_glitch();
    test_auto_repeat();
    test_overflow();
    test_clear_and_count();
    test_reset_mid_repeat();
    wait_cycles(5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d required completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
